// File: rtl/timer_pkg.sv
// Shared types and constants for the interval timer block.
package timer_pkg;

  localparam int TIMER_W          = 8;
  localparam int PRESCALE_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_e;

endpackage

// File: rtl/up_counter.sv
// Existing 8-bit up counter datapath: synchronous clear via rst, counts when en.
module up_counter
  import timer_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: hold or increment by one.
  always_comb begin
    count_d = count_q;
    if (en) count_d = count_q + 1'b1;
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: sequences an up_counter through IDLE/RUN/PAUSE,
// emitting a registered one-cycle done pulse at expiry (one-shot or periodic).
// Optional macro TIMER_PRESCALE_EN inserts a PRESCALE-cycle step divider.
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic               periodic,
  input  logic [TIMER_W-1:0] period,
  output logic [TIMER_W-1:0] count,
  output logic               busy,
  output logic               paused,
  output logic               done
);

  // Divider range is checked at elaboration in every build.
  if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_prescale
    $error("interval_timer_ctrl: PRESCALE must be in 2..256");
  end

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] period_q, period_d;
  logic               periodic_q, periodic_d;
  logic               done_q, done_d;
  logic [TIMER_W-1:0] cnt;
  logic               active;
  logic               tick;
  logic               step;
  logic               terminal;
  logic               clear;

  assign active = (state_q != IDLE);

`ifdef TIMER_PRESCALE_EN
  localparam int                PS_W     = $clog2(PRESCALE);
  localparam logic [PS_W-1:0]   PRE_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] pre_q, pre_d;

  assign tick = (pre_q == PRE_LAST);

  // Prescaler advances only while running and not held; zero whenever idle.
  always_comb begin
    pre_d = pre_q;
    if (!active || state_d == IDLE) pre_d = '0;
    else if (!hold)                 pre_d = tick ? '0 : pre_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end
`else
  assign tick = 1'b1;
`endif

  assign step     = active & ~hold & tick;
  assign terminal = step & (cnt == period_q);

  // Next-state, latches, counter clear and done; stop beats terminal beats hold.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    periodic_d = periodic_q;
    done_d     = 1'b0;
    clear      = 1'b0;
    case (state_q)
      IDLE: begin
        clear = 1'b1;
        if (start && !stop) begin
          state_d    = RUN;
          period_d   = period;
          periodic_d = periodic;
        end
      end
      RUN, PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          clear   = 1'b1;
        end else if (terminal) begin
          clear   = 1'b1;
          done_d  = 1'b1;
          state_d = periodic_q ? RUN : IDLE;
        end else if (hold) begin
          state_d = PAUSE;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        clear   = 1'b1;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      period_q   <= '0;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
      done_q     <= done_d;
    end
  end

  up_counter #(.W(TIMER_W)) u_cnt (
    .clk   (clk),
    .rst   (rst | clear),
    .en    (step),
    .count (cnt)
  );

  assign count  = cnt;
  assign busy   = active;
  assign paused = (state_q == PAUSE);
  assign done   = done_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl: directed scenarios plus random
// stimulus, compared every cycle against a step-counting reference model.
module tb_interval_timer_ctrl;

  localparam int PRESCALE = 4;
`ifdef TIMER_PRESCALE_EN
  localparam int PS_EFF = PRESCALE;
`else
  localparam int PS_EFF = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, start, stop, hold, periodic;
  logic [7:0] period;
  logic [7:0] count;
  logic       busy, paused, done;

  always #5 clk = ~clk;

  interval_timer_ctrl #(.PRESCALE(PRESCALE)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .hold     (hold),
    .periodic (periodic),
    .period   (period),
    .count    (count),
    .busy     (busy),
    .paused   (paused),
    .done     (done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: a timer run is a number of steps taken since start;
  // count is steps mod (P+1), and each multiple of P+1 is an expiry.
  int m_busy = 0, m_paused = 0, m_done = 0;
  int m_p = 0, m_per = 0, m_steps = 0, m_ph = 0;

  int cyc_no;
  int done_at[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int m_count();
    return m_busy ? (m_steps % (m_p + 1)) : 0;
  endfunction

  task automatic model_step(input logic r, s, sp, h, per, input logic [7:0] p);
    bit tk;
    if (r) begin
      m_busy = 0; m_paused = 0; m_done = 0; m_p = 0; m_per = 0; m_steps = 0; m_ph = 0;
    end else if (m_busy == 0) begin
      m_done = 0; m_paused = 0;
      if (s && !sp) begin
        m_busy = 1; m_p = int'(p); m_per = int'(per); m_steps = 0; m_ph = 0;
      end
    end else if (sp) begin
      m_busy = 0; m_done = 0; m_paused = 0; m_steps = 0; m_ph = 0;
    end else begin
      tk = (PS_EFF == 1) ? 1'b1 : (m_ph == PS_EFF - 1);
      if (!h) m_ph = (m_ph + 1) % PS_EFF;
      m_done = 0;
      if (!h && tk) begin
        m_steps++;
        if (m_steps % (m_p + 1) == 0) begin
          m_done = 1;
          if (m_per == 0) begin
            m_busy = 0; m_steps = 0; m_ph = 0;
          end
        end
      end
      m_paused = (m_busy != 0 && h) ? 1 : 0;
    end
  endtask

  // One clock: drive at negedge, model the edge, check at next negedge.
  task automatic cyc(input logic r, s, sp, h, per, input logic [7:0] p);
    rst = r; start = s; stop = sp; hold = h; periodic = per; period = p;
    @(posedge clk);
    model_step(r, s, sp, h, per, p);
    @(negedge clk);
    chk("count",  int'(count),  m_count());
    chk("busy",   int'(busy),   m_busy);
    chk("paused", int'(paused), m_paused);
    chk("done",   int'(done),   m_done);
    cyc_no++;
    if (done) done_at.push_back(cyc_no);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic settle();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    idle(1);
  endtask

  function automatic int q_at(input int idx);
    return (done_at.size() > idx) ? done_at[idx] : -1;
  endfunction

  int last;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; periodic = 1'b0; period = 8'd0;
    @(negedge clk);

    // Reset held two cycles while start is requested.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    idle(2);

    // One-shot P=5.
    done_at.delete(); cyc_no = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    idle(PS_EFF * 6 + 2);
    chk("oneshot_n",   done_at.size(), 1);
    chk("oneshot_cyc", q_at(0), 1 + PS_EFF * 6);

    // Periodic P=3, then stop the cycle after the third done.
    done_at.delete(); cyc_no = 0;
    last = 1 + 3 * PS_EFF * 4;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3);
    idle(last);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("per_stop_busy", int'(busy), 0);
    idle(PS_EFF * 8);
    chk("per_n",  done_at.size(), 3);
    chk("per_d0", q_at(0), 1 + 1 * PS_EFF * 4);
    chk("per_d1", q_at(1), 1 + 2 * PS_EFF * 4);
    chk("per_d2", q_at(2), 1 + 3 * PS_EFF * 4);

    // Hold one-shot P=4 during cycles 3..5.
    done_at.delete(); cyc_no = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    idle(2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    idle(PS_EFF * 5 + 2);
    chk("hold_n",   done_at.size(), 1);
    chk("hold_cyc", q_at(0), 1 + PS_EFF * 5 + 3);

    // Stop in the terminal cycle suppresses done.
    done_at.delete(); cyc_no = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    idle(PS_EFF * 3 - 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    idle(PS_EFF * 4);
    chk("stop_term_n", done_at.size(), 0);

    // Start with P=9 while busy is ignored.
    done_at.delete(); cyc_no = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd9);
    idle(PS_EFF * 12);
    chk("busy_start_n",   done_at.size(), 1);
    chk("busy_start_cyc", q_at(0), 1 + PS_EFF * 4);

    // Periodic P=0: done every step from the first.
    done_at.delete(); cyc_no = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    idle(6 * PS_EFF);
    settle();
    chk("p0_n",   done_at.size(), 6);
    chk("p0_d0",  q_at(0), 1 + PS_EFF);
    chk("p0_d5",  q_at(5), 1 + 6 * PS_EFF);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic r, s, sp, h, per;
      logic [7:0] p;
      r   = ($urandom_range(0, 299) == 0);
      s   = ($urandom_range(0, 3) == 0);
      sp  = ($urandom_range(0, 59) == 0);
      h   = ($urandom_range(0, 5) == 0);
      per = $urandom_range(0, 1);
      p   = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      cyc(r, s, sp, h, per, p);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
